// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: data width, register address width
// and the fixed requester slot assignment.
package wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_MUL = 1;
  localparam int REQ_LSU = 2;

  // Pointer width; a single requester still needs a 1-bit pointer.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set valid bit at or above ptr, wrapping modulo N.
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic [2*N-1:0] rot;
  logic [PW:0]    sum;
  logic           found;

  // Rotating a doubled copy right by ptr puts the search order at bit 0 upward.
  always_comb begin
    rot   = {valid, valid} >> ptr;
    sum   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (PW+1)'(j);
      end
    end
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    idx   = sum[PW-1:0];
    grant = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant among NREQ requesters onto a single
// registered register-file write port, with a committed-write counter.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = wb_arbiter_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*RA_W-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [RA_W-1:0]      rf_wa,
  output logic [XLEN-1:0]      rf_wd,
  output logic [31:0]          wb_cnt
);

  localparam int PW = ptr_w(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   ptr_next;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic            xfer;
  logic [RA_W-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     cnt_q;

  rr_pick #(
    .N (NREQ),
    .PW(PW)
  ) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(pick_grant),
    .idx  (pick_idx)
  );

  always_comb begin
    req_ready = (reset_n && !flush) ? pick_grant : '0;
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_rd   = req_rd[i*RA_W +: RA_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign ptr_next = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + 1'b1;

  // Writes to x0 are accepted and advance the pointer but never assert rf_we.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
      cnt_q  <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_next;
      rf_we  <= |sel_rd;
      rf_wa  <= sel_rd;
      rf_wd  <= sel_data;
      if (|sel_rd) cnt_q <= cnt_q + 32'd1;
    end else begin
      rf_we  <= 1'b0;
    end
  end

  assign wb_cnt = cnt_q;

endmodule
